// File: rtl/spi_byte_shifter_pkg.sv
// Shared types and register map for the SPI byte shifter.
package spi_byte_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_LVL   = 4;

  // The status field is 4 bits wide; deeper FIFOs saturate at 15.
  function automatic logic [3:0] lvl_field(input int unsigned lvl);
    logic [31:0] v;
    v = lvl;
    return (lvl > 15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/spi_byte_shifter_if.sv
// Avalon-MM slave bus bundle for the SPI byte shifter.
interface spi_byte_shifter_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO with simultaneous push/pop and occupancy level.
module spi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: Avalon byte FIFO feeding an MSB-first shifter
// with per-byte DC and PIO-driven chip select / reset / enable.
module spi_byte_shifter
  import spi_byte_shifter_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  spi_byte_shifter_if.slave   bus,
  input  logic [3:0]          pio_in,
  input  logic                spi_miso,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                spi_cs_n,
  output logic                spi_dc,
  output logic                spi_rst_n
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_nxt;
  logic [7:0]    div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr, rx_sr, rx_reg;
  logic          dc_cur, ovf;
  logic          wr, push, drop, full, empty, go, load_now, div_end;
  logic [8:0]    head;
  logic [LW-1:0] level;
  logic          unused_wdata;

  assign wr       = bus.chipselect && !bus.write_n;
  assign push     = wr && (bus.address == ADDR_DATA);
  assign go       = !empty && pio_in[3];
  assign div_end  = (div_cnt == 8'(CLK_DIV - 1));
  // DONE doubles as LOAD when another byte follows, removing a cycle per byte.
  assign load_now = (state == ST_LOAD) || (state == ST_DONE && go);
  assign drop     = push && full && !load_now;
  assign spi_mosi = tx_sr[7];
  assign unused_wdata = ^bus.writedata[31:8];

  spi_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (load_now),
    .din   ({pio_in[1], bus.writedata[7:0]}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_LOW;
      ST_LOW:  if (div_end) state_nxt = ST_HIGH;
      ST_HIGH: if (div_end) state_nxt = (bit_cnt == 3'd7) ? ST_DONE : ST_LOW;
      ST_DONE: state_nxt = go ? ST_LOW : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_reg  <= '0;
      dc_cur  <= 1'b0;
      ovf     <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_dc    <= 1'b0;
      spi_rst_n <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= ((state == ST_LOW || state == ST_HIGH) && !div_end) ? div_cnt + 8'd1 : 8'd0;
      if (load_now) begin
        tx_sr   <= head[7:0];
        dc_cur  <= head[8];
        bit_cnt <= '0;
      end
      if (state == ST_LOW && div_end) rx_sr <= {rx_sr[6:0], spi_miso};
      if (state == ST_HIGH && div_end) begin
        tx_sr   <= {tx_sr[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == ST_DONE) rx_reg <= rx_sr;
      if (drop) ovf <= 1'b1;
      else if (wr && bus.address == ADDR_STATUS && bus.writedata[STAT_OVF]) ovf <= 1'b0;
      // Pins follow next state so they line up with the FSM cycle they describe.
      spi_sclk  <= (state_nxt == ST_HIGH);
      spi_cs_n  <= pio_in[0] & (state_nxt == ST_IDLE);
      spi_rst_n <= pio_in[2];
      if (state_nxt == ST_IDLE)                    spi_dc <= pio_in[1];
      else if (load_now || state_nxt == ST_LOAD)   spi_dc <= head[8];
      else                                         spi_dc <= dc_cur;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata[7:0] = rx_reg;
      ADDR_STATUS: begin
        bus.readdata[STAT_BUSY]  = (state != ST_IDLE);
        bus.readdata[STAT_FULL]  = full;
        bus.readdata[STAT_EMPTY] = empty;
        bus.readdata[STAT_OVF]   = ovf;
        bus.readdata[STAT_LVL +: 4] = lvl_field(int'(level));
      end
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Self-checking bench: register table, MOSI/DC scoreboard, multi-cycle corners.
module tb_spi_byte_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pio;
  logic       miso;
  logic       spi_sclk, spi_mosi, spi_cs_n, spi_dc, spi_rst_n;

  spi_byte_shifter_if bus();

  spi_byte_shifter #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .pio_in    (pio),
    .spi_miso  (miso),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_dc    (spi_dc),
    .spi_rst_n (spi_rst_n)
  );

  assign miso = spi_mosi;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [8:0] tx_q[$];
  int   mon_n = 0, rise_cnt = 0, cs_cnt = 0, bytes_seen = 0;
  logic [7:0] mon_byte = '0;
  logic mon_dc = 1'b0, mon_dc_chg = 1'b0, sclk_prev = 1'b0;

  typedef struct {
    bit        do_wr;
    bit        accept;
    bit [2:0]  waddr;
    bit [31:0] wdata;
    bit [2:0]  raddr;
    bit [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (spi_sclk && !sclk_prev) begin
      if (mon_n == 0) mon_dc = spi_dc;
      else if (spi_dc !== mon_dc) mon_dc_chg = 1'b1;
      mon_byte = {mon_byte[6:0], spi_mosi};
      mon_n++;
      rise_cnt++;
      if (mon_n == 8) begin
        if (tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mosi_byte: got unexpected %h want none", mon_byte);
        end else begin
          e = tx_q.pop_front();
          check("mosi_byte", {22'b0, mon_dc_chg, mon_dc, mon_byte}, {23'b0, e});
        end
        mon_n = 0; mon_dc_chg = 1'b0; bytes_seen++;
      end
    end
    sclk_prev = spi_sclk;
    if (!spi_cs_n) cs_cnt++;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic wr_data(input logic [7:0] b);
    tx_q.push_back({pio[1], b});
    wr(3'd0, {24'h0, b});
  endtask

  task automatic run_idle(input int maxc, input string nm);
    logic [31:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      rd(3'd1, s);
      if (!s[0] && (s[2] || !pio[3])) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s: got timeout want idle", nm); end
  endtask

  task automatic run_rises(input int n, input int maxc, input string nm);
    int target = rise_cnt + n;
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (rise_cnt >= target) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s: got timeout want sclk rises", nm); end
  endtask

  initial begin
    logic [31:0] r;
    int b0;

    // enable=0 register table: reset state, pushes, overflow, ignored address, clear
    tbl[0] = '{0, 0, 3'd0, 32'h0,  3'd1, 32'h04};
    tbl[1] = '{0, 0, 3'd0, 32'h0,  3'd0, 32'h00};
    tbl[2] = '{0, 0, 3'd0, 32'h0,  3'd5, 32'h00};
    tbl[3] = '{1, 1, 3'd0, 32'h11, 3'd1, 32'h10};
    tbl[4] = '{1, 1, 3'd0, 32'h22, 3'd1, 32'h20};
    tbl[5] = '{1, 1, 3'd0, 32'h33, 3'd1, 32'h30};
    tbl[6] = '{1, 1, 3'd0, 32'h44, 3'd1, 32'h42};
    tbl[7] = '{1, 0, 3'd0, 32'h55, 3'd1, 32'h4A};
    tbl[8] = '{1, 0, 3'd7, 32'hFF, 3'd1, 32'h4A};
    tbl[9] = '{1, 0, 3'd1, 32'h08, 3'd1, 32'h42};

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    pio = 4'b0101;
    reset = 1'b1;
    tick(); tick();
    check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("rst_dc",   {31'b0, spi_dc},   32'd0);
    check("rst_rst_n", {31'b0, spi_rst_n}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_n_follow", {31'b0, spi_rst_n}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_wr) begin
        if (tbl[i].accept) tx_q.push_back({pio[1], tbl[i].wdata[7:0]});
        wr(tbl[i].waddr, tbl[i].wdata);
      end
      rd(tbl[i].raddr, r);
      check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    b0 = bytes_seen;
    pio[3] = 1'b1;
    run_idle(400, "ovf_drain");
    check("ovf_bytes", bytes_seen - b0, 32'd4);
    check("ovf_q_empty", tx_q.size(), 32'd0);
    rd(3'd1, r); check("ovf_status_end", r, 32'h04);

    // basic transfer, loopback
    cs_cnt = 0;
    wr_data(8'hA5);
    run_idle(200, "basic_idle");
    check("basic_cycles", cs_cnt, 32'd34);
    rd(3'd0, r); check("basic_rx", r, 32'hA5);
    check("basic_cs_hi", {31'b0, spi_cs_n}, 32'd1);

    // per-byte DC, back-to-back
    pio[3] = 1'b0;
    pio[1] = 1'b0; wr_data(8'h2A);
    pio[1] = 1'b1; wr_data(8'h55);
    pio[1] = 1'b0;
    cs_cnt = 0;
    pio[3] = 1'b1;
    run_idle(300, "dc_idle");
    check("dc_no_gap", cs_cnt, 32'd67);
    rd(3'd0, r); check("dc_rx", r, 32'h55);

    // enable drop mid-byte
    pio[3] = 1'b0;
    wr_data(8'h81); wr_data(8'h7E);
    pio[3] = 1'b1;
    run_rises(3, 100, "drop_rises");
    pio[3] = 1'b0;
    run_idle(200, "drop_idle");
    rd(3'd1, r); check("drop_status", r, 32'h10);
    check("drop_q", tx_q.size(), 32'd1);
    rd(3'd0, r); check("drop_rx", r, 32'h81);
    pio[3] = 1'b1;
    run_idle(200, "drop_resume");
    rd(3'd1, r); check("drop_status_end", r, 32'h04);

    // push in the same cycle LOAD pops the only entry
    pio[3] = 1'b0;
    wr_data(8'h3C);
    pio[3] = 1'b1;
    tick();
    rd(3'd1, r); check("lastpop_load", r, 32'h11);
    wr_data(8'hC3);
    rd(3'd1, r); check("lastpop_level", r, 32'h11);
    run_idle(300, "lastpop_idle");
    check("lastpop_q", tx_q.size(), 32'd0);
    rd(3'd0, r); check("lastpop_rx", r, 32'hC3);

    // reset during HIGH of bit 4
    pio[3] = 1'b0;
    wr_data(8'hF0); wr_data(8'h0F);
    pio[3] = 1'b1;
    run_rises(4, 100, "rst_rises");
    check("rst_in_high", {31'b0, spi_sclk}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("mid_rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("mid_rst_rst_n", {31'b0, spi_rst_n}, 32'd0);
    rd(3'd1, r); check("mid_rst_status", r, 32'h04);
    rd(3'd0, r); check("mid_rst_rx", r, 32'h00);
    reset = 1'b0;
    tx_q.delete();
    mon_n = 0; mon_dc_chg = 1'b0;
    tick(); tick();
    rd(3'd1, r); check("post_rst_status", r, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
